// File: rtl/mips_pipe_pkg.sv
// Shared pipeline-register types: exception encoding and the per-slot field layout.
package mips_pipe_pkg;
  localparam int EXC_W = 5;
  localparam logic [EXC_W-1:0] EXC_NONE = '0;

  typedef struct packed {
    logic             valid;
    logic [31:0]      ir;
    logic [31:0]      pc;
    logic [31:0]      pc4;
    logic [EXC_W-1:0] exc;
    logic             bd;
  } slot_t;
endpackage

// File: rtl/pipe_reg_if.sv
// Pipeline-register bus: control, input payload, output payload and stall count.
interface pipe_reg_if #(parameter int CNT_W = 16);
  import mips_pipe_pkg::*;

  logic             stop;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_ir;
  logic [31:0]      in_pc;
  logic [31:0]      in_pc4;
  logic [EXC_W-1:0] in_exc;
  logic             in_bd;
  logic             out_valid;
  logic [31:0]      out_ir;
  logic [31:0]      out_pc;
  logic [31:0]      out_pc4;
  logic [EXC_W-1:0] out_exc;
  logic             out_bd;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stop, flush, in_valid, in_ir, in_pc, in_pc4, in_exc, in_bd,
    input  out_valid, out_ir, out_pc, out_pc4, out_exc, out_bd, stall_cnt
  );
  modport slave (
    input  stop, flush, in_valid, in_ir, in_pc, in_pc4, in_exc, in_bd,
    output out_valid, out_ir, out_pc, out_pc4, out_exc, out_bd, stall_cnt
  );
endinterface

// File: rtl/pipe_reg_slot.sv
// One pipeline slot: reset > flush > stop > load.
module pipe_reg_slot
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_IR        = 32'h0000_0000,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          FLUSH_KEEP_PC = 1'b0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stop,
  input  logic  flush,
  input  slot_t d,
  output slot_t q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '{valid: 1'b0, ir: NOP_IR, pc: RESET_PC, pc4: RESET_PC, exc: EXC_NONE, bd: 1'b0};
    end else if (flush) begin
      q.valid <= 1'b0;
      q.ir    <= NOP_IR;
      q.exc   <= EXC_NONE;
      // Keeping pc/pc4/bd lets the exception handler still see where the bubble came from.
      if (!FLUSH_KEEP_PC) begin
        q.pc  <= RESET_PC;
        q.pc4 <= RESET_PC;
        q.bd  <= 1'b0;
      end
    end else if (!stop) begin
      q <= d;
    end
  end
endmodule

// File: rtl/pipe_reg.sv
// Chained pipeline register of DEPTH slots with a saturating stall-cycle counter.
module pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int          DEPTH         = 1,
  parameter logic [31:0] NOP_IR        = 32'h0000_0000,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          FLUSH_KEEP_PC = 1'b0,
  parameter int          CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  pipe_reg_if.slave  bus
);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_reg: DEPTH must be in 1..4");
  end

  slot_t             d0;
  slot_t [DEPTH:0]   chain;
  logic  [CNT_W-1:0] cnt;

  // An invalid input becomes a bubble but still carries its pc/pc4.
  always_comb begin
    d0 = '{valid: 1'b1, ir: bus.in_ir, pc: bus.in_pc, pc4: bus.in_pc4,
           exc: bus.in_exc, bd: bus.in_bd};
    if (!bus.in_valid) begin
      d0.valid = 1'b0;
      d0.ir    = NOP_IR;
      d0.exc   = EXC_NONE;
      d0.bd    = 1'b0;
    end
  end

  assign chain[0] = d0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipe_reg_slot #(
      .NOP_IR       (NOP_IR),
      .RESET_PC     (RESET_PC),
      .FLUSH_KEEP_PC(FLUSH_KEEP_PC)
    ) u_slot (
      .clk  (clk),
      .reset(reset),
      .stop (bus.stop),
      .flush(bus.flush),
      .d    (chain[k]),
      .q    (chain[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (bus.stop && !bus.flush && cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end

  assign bus.out_valid = chain[DEPTH].valid;
  assign bus.out_ir    = chain[DEPTH].ir;
  assign bus.out_pc    = chain[DEPTH].pc;
  assign bus.out_pc4   = chain[DEPTH].pc4;
  assign bus.out_exc   = chain[DEPTH].exc;
  assign bus.out_bd    = chain[DEPTH].bd;
  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_pipe_reg.sv
// Two pipe_reg configurations on shared stimulus, checked by a scoreboard against a slot-array model.
module tb_pipe_reg;
  import mips_pipe_pkg::*;

  localparam int          DEP0 = 3;
  localparam int          DEP1 = 1;
  localparam logic [31:0] NOP0 = 32'h0000_0000;
  localparam logic [31:0] NOP1 = 32'h0000_000D;
  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hBFC0_0000;

  typedef struct packed {
    slot_t       o0;
    slot_t       o1;
    logic [15:0] c0;
    logic [15:0] c1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stp = 1'b0, fl = 1'b0, iv = 1'b0, bdi = 1'b0;
  logic [31:0] iri = '0, pci = '0, pc4i = '0;
  logic [4:0]  exci = '0;

  int    n_chk = 0;
  int    n_fail = 0;
  exp_t  exp_q[$];
  slot_t mdl [2][4];
  int    mcnt [2];
  slot_t o0, o1;

  always #5 clk = ~clk;

  pipe_reg_if #(.CNT_W(4))  b0();
  pipe_reg_if #(.CNT_W(16)) b1();

  assign b0.stop = stp;  assign b0.flush = fl;   assign b0.in_valid = iv;
  assign b0.in_ir = iri; assign b0.in_pc = pci;  assign b0.in_pc4 = pc4i;
  assign b0.in_exc = exci; assign b0.in_bd = bdi;
  assign b1.stop = stp;  assign b1.flush = fl;   assign b1.in_valid = iv;
  assign b1.in_ir = iri; assign b1.in_pc = pci;  assign b1.in_pc4 = pc4i;
  assign b1.in_exc = exci; assign b1.in_bd = bdi;

  assign o0 = {b0.out_valid, b0.out_ir, b0.out_pc, b0.out_pc4, b0.out_exc, b0.out_bd};
  assign o1 = {b1.out_valid, b1.out_ir, b1.out_pc, b1.out_pc4, b1.out_exc, b1.out_bd};

  pipe_reg #(.DEPTH(DEP0), .NOP_IR(NOP0), .RESET_PC(RPC0), .FLUSH_KEEP_PC(1'b0), .CNT_W(4))
    u0 (.clk(clk), .reset(rst), .bus(b0.slave));
  pipe_reg #(.DEPTH(DEP1), .NOP_IR(NOP1), .RESET_PC(RPC1), .FLUSH_KEEP_PC(1'b1), .CNT_W(16))
    u1 (.clk(clk), .reset(rst), .bus(b1.slave));

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: slot array per DUT, index 0 nearest the input.
  task automatic model(input int d);
    int          dp;
    int          cmax;
    bit          keep;
    logic [31:0] nop, rpc;
    dp   = (d == 0) ? DEP0 : DEP1;
    cmax = (d == 0) ? 15 : 65535;
    keep = (d == 1);
    nop  = (d == 0) ? NOP0 : NOP1;
    rpc  = (d == 0) ? RPC0 : RPC1;
    if (rst) begin
      for (int k = 0; k < dp; k++)
        mdl[d][k] = '{valid: 1'b0, ir: nop, pc: rpc, pc4: rpc, exc: 5'd0, bd: 1'b0};
      mcnt[d] = 0;
    end else if (fl) begin
      for (int k = 0; k < dp; k++) begin
        mdl[d][k].valid = 1'b0;
        mdl[d][k].ir    = nop;
        mdl[d][k].exc   = 5'd0;
        if (!keep) begin
          mdl[d][k].pc  = rpc;
          mdl[d][k].pc4 = rpc;
          mdl[d][k].bd  = 1'b0;
        end
      end
    end else if (stp) begin
      if (mcnt[d] < cmax) mcnt[d]++;
    end else begin
      for (int k = dp - 1; k > 0; k--) mdl[d][k] = mdl[d][k-1];
      if (iv) mdl[d][0] = '{valid: 1'b1, ir: iri, pc: pci, pc4: pc4i, exc: exci, bd: bdi};
      else    mdl[d][0] = '{valid: 1'b0, ir: nop, pc: pci, pc4: pc4i, exc: 5'd0, bd: 1'b0};
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit v,
                      input logic [31:0] i, input logic [31:0] p,
                      input logic [4:0] e, input bit b);
    rst = r; stp = s; fl = f; iv = v; iri = i; pci = p; pc4i = p + 32'd4; exci = e; bdi = b;
    model(0);
    model(1);
    @(posedge clk);
    exp_q.push_back('{o0: mdl[0][DEP0-1], o1: mdl[1][DEP1-1],
                      c0: 16'(mcnt[0]), c1: 16'(mcnt[1])});
    #1;
  endtask

  // Monitor: every cycle both DUTs present their slot contents.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_d0_out", 128'(o0), 128'(e.o0));
      check("sb_d1_out", 128'(o1), 128'(e.o1));
      check("sb_d0_cnt", 128'(b0.stall_cnt), 128'(e.c0));
      check("sb_d1_cnt", 128'(b1.stall_cnt), 128'(e.c1));
    end
  end

  initial begin
    logic [31:0] rp;
    step(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
    step(1, 1, 1, 1, 32'h1234, 32'h100, 5'd3, 1);
    check("rst_valid", 128'(b0.out_valid), 128'(0));
    check("rst_cnt",   128'(b0.stall_cnt), 128'(0));
    check("rst_pc1",   128'(b1.out_pc),    128'(32'hBFC0_0000));

    // Single-slot load
    step(0, 0, 0, 1, 32'h2408_0005, 32'h3000, 5'd0, 0);
    check("load_ir",    128'(b1.out_ir),    128'(32'h2408_0005));
    check("load_pc",    128'(b1.out_pc),    128'(32'h3000));
    check("load_valid", 128'(b1.out_valid), 128'(1));

    // Three-deep latency, then four stalled cycles
    step(0, 0, 0, 1, 32'd1, 32'h3000, 5'd0, 0);
    step(0, 0, 0, 1, 32'd2, 32'h3004, 5'd0, 0);
    step(0, 0, 0, 1, 32'd3, 32'h3008, 5'd0, 0);
    check("lat3_ir", 128'(b0.out_ir), 128'(1));
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 1, $urandom(), 32'h5000, 5'd0, 0);
      check("stall_freeze", 128'(b0.out_ir), 128'(1));
    end
    check("stall_cnt0", 128'(b0.stall_cnt), 128'(4));
    check("stall_cnt1", 128'(b1.stall_cnt), 128'(4));

    // Flush wins over stop
    step(0, 1, 1, 1, 32'h7, 32'h6000, 5'd2, 1);
    check("fl_valid", 128'(b0.out_valid), 128'(0));
    check("fl_ir",    128'(b0.out_ir),    128'(0));
    check("fl_pc",    128'(b0.out_pc),    128'(0));
    check("fl_cnt",   128'(b0.stall_cnt), 128'(4));

    // Flush that preserves pc/bd
    step(0, 0, 0, 1, 32'h5, 32'h3008, 5'd0, 1);
    check("kp_pre_pc", 128'(b1.out_pc), 128'(32'h3008));
    check("kp_pre_bd", 128'(b1.out_bd), 128'(1));
    step(0, 1, 1, 1, 32'h9, 32'h7000, 5'd0, 0);
    check("kp_pc",    128'(b1.out_pc),    128'(32'h3008));
    check("kp_bd",    128'(b1.out_bd),    128'(1));
    check("kp_valid", 128'(b1.out_valid), 128'(0));

    // Invalid input becomes a bubble carrying its pc
    step(0, 0, 0, 0, 32'hFFFF_FFFF, 32'h4000, 5'd4, 1);
    check("inv_ir",    128'(b1.out_ir),    128'(NOP1));
    check("inv_exc",   128'(b1.out_exc),   128'(0));
    check("inv_valid", 128'(b1.out_valid), 128'(0));
    check("inv_pc",    128'(b1.out_pc),    128'(32'h4000));

    // Counter saturation and reset mid-stall/mid-flush
    step(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 1, $urandom(), 32'h8000, 5'd0, 0);
    check("sat_cnt0", 128'(b0.stall_cnt), 128'(15));
    check("sat_cnt1", 128'(b1.stall_cnt), 128'(20));
    step(1, 1, 1, 1, 32'h1, 32'h9000, 5'd1, 1);
    check("rst_sat_cnt", 128'(b0.stall_cnt), 128'(0));
    check("rst_stall_v", 128'(b1.out_valid), 128'(0));

    for (int n = 0; n < 400; n++) begin
      rp = $urandom();
      rp[1:0] = 2'b00;
      step($urandom_range(99) < 3, $urandom_range(99) < 30, $urandom_range(99) < 10,
           $urandom_range(99) < 75, $urandom(), rp, 5'($urandom_range(31)),
           1'($urandom_range(1)));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter DEPTH, default 1, meaning the number of chained register slots between input and output (legal values 1..4).
REQ-002 Parameter NOP_IR, default 32'h0000_0000, meaning the instruction word loaded into a slot by reset, flush or an invalid input.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, meaning the PC and PC4 value held after reset.
REQ-004 Parameter FLUSH_KEEP_PC, default 0, meaning that when set to 1, a flushed slot keeps its PC, PC4 and BD fields so the exception PC stays traceable.
REQ-005 Parameter CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  reset is synchronous and active-high.
REQ-008 stop  input  1  stall; freezes every slot.
REQ-009 flush  input  1  squashes every slot to a bubble.
REQ-010 in_valid  input  1  the input payload is a real instruction.
REQ-011 in_ir  input  32  instruction word.
REQ-012 in_pc  input  32  instruction address.
REQ-013 in_pc4  input  32  instruction address + 4.
REQ-014 in_exc  input  5  exception code (EXC_NONE = 0).
REQ-015 in_bd  input  1  the instruction sits in a branch delay slot.
REQ-016 out_valid, out_ir, out_pc, out_pc4, out_exc, out_bd  output  1/32/32/32/5/1  contents of the last slot, driven directly from registers.
REQ-017 stall_cnt  output  CNT_W  number of stalled cycles.

Function
REQ-018 Each slot shall hold the fields {valid, ir, pc, pc4, exc, bd}.
REQ-019 Update priority per cycle shall be reset > flush > stop > load.
REQ-020 On load, slot 0 shall capture the input and slot k shall capture slot k-1, so latency is exactly DEPTH cycles from input to output.
REQ-021 On load with in_valid=0, slot 0 shall capture valid=0, ir=NOP_IR, exc=EXC_NONE and bd=0, while pc and pc4 still take the input values.
REQ-022 On stop=1 with flush=0, all slots shall hold their values unchanged, including valid.
REQ-023 On flush=1, every slot shall set valid=0, ir=NOP_IR and exc=EXC_NONE; flush overrides a simultaneous stop.
REQ-024 On flush=1 with FLUSH_KEEP_PC=0, pc and pc4 shall become RESET_PC and bd shall become 0.
REQ-025 On flush=1 with FLUSH_KEEP_PC=1, pc, pc4 and bd shall keep their prior values.
REQ-026 stall_cnt shall increment by 1 in each cycle where stop=1, flush=0 and reset=0.
REQ-027 stall_cnt shall saturate at 2^CNT_W-1 and never wrap.
REQ-028 stall_cnt shall be unaffected by flush.
REQ-029 Outputs shall change only on a rising clk edge, with no combinational path from any input to any output.
REQ-030 A DEPTH value outside 1..4 shall be rejected at elaboration.

Reset
REQ-031 While reset=1 at a rising edge, every slot shall take valid=0, ir=NOP_IR, pc=pc4=RESET_PC, exc=EXC_NONE and bd=0, and stall_cnt shall be cleared to 0.
REQ-032 Reset asserted mid-stall or mid-flush shall win in that cycle.
REQ-033 On the first cycle after reset deasserts, normal priority shall resume.
REQ-034 No output shall be undefined after the first reset edge.

Structure
REQ-035 The constants EXC_NONE and EXC_W=5 and the slot field layout shall live in the shared package mips_pipe_pkg.
REQ-036 A single slot shall be the sub-module pipe_reg_slot, instantiated DEPTH times in a generate loop.
REQ-037 The stall counter shall live in pipe_reg itself.

Verification
REQ-038 Load test: DEPTH=1, reset, then load in_ir=32'h2408_0005, in_pc=32'h3000, in_pc4=32'h3004, in_valid=1 -> on the next cycle out_ir=32'h2408_0005, out_pc=32'h3000, out_valid=1.
REQ-039 Latency and stall test: DEPTH=3, feed ir values 1, 2, 3, then hold stop=1 for 4 cycles -> out_ir first shows 1 three cycles after the first load, the outputs freeze for the 4 stalled cycles, and stall_cnt=4.
REQ-040 Flush-over-stop test: flush=1 and stop=1 in the same cycle, with FLUSH_KEEP_PC=0 -> next cycle out_valid=0, out_ir=0, out_pc=0.
REQ-041 Keep-PC test: repeat REQ-040 with FLUSH_KEEP_PC=1, out_pc=32'h3008 and out_bd=1 before the flush -> after the flush out_pc=32'h3008, out_bd=1, out_valid=0.
REQ-042 Saturation test: CNT_W=4, hold stop=1 for 20 cycles -> stall_cnt reaches 15 and stays at 15; a later reset -> stall_cnt=0.
REQ-043 Invalid-input test: load with in_valid=0, in_ir=32'hFFFF_FFFF, in_exc=4 -> out_ir=NOP_IR, out_exc=0, out_valid=0, out_pc equal to in_pc.
